// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access sequencer.
package mem_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    RMW_RD = 3'd2,
    RMW_WR = 3'd3,
    DONE   = 3'd4
  } state_t;

  localparam logic [3:0] REGION_ROM = 4'h0;
  localparam logic [3:0] REGION_RAM = 4'h1;
  localparam logic [3:0] REGION_IO  = 4'hf;

  localparam logic [1:0] MODE_WORD   = 2'b00;
  localparam logic [1:0] MODE_BYTE_S = 2'b01;
  localparam logic [1:0] MODE_BYTE_U = 2'b10;

  // Mode 11 is reserved and behaves as a word access.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    logic [1:0] r;
    case (m)
      MODE_BYTE_S: r = MODE_BYTE_S;
      MODE_BYTE_U: r = MODE_BYTE_U;
      default:     r = MODE_WORD;
    endcase
    return r;
  endfunction

  function automatic logic is_byte_mode(input logic [1:0] m);
    return (m == MODE_BYTE_S) || (m == MODE_BYTE_U);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// CPU request port and exmemory port of the sequencer, bundled as one interface.
interface mem_access_ctrl_if #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16
) ();

  logic                  req;
  logic                  we;
  logic [1:0]            mode;
  logic [ADDR_WIDTH-1:0] addr;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH-1:0]      rdata;
  logic                  ready;
  logic                  err;
  logic                  busy;
  logic                  MemWrite;
  logic [1:0]            MemMode;
  logic [ADDR_WIDTH-1:0] memAddr;
  logic [WIDTH-1:0]      memWriteData;
  logic [WIDTH-1:0]      memReadData;

  // master = requester plus memory environment; slave = the sequencer.
  modport master (
    output req, we, mode, addr, wdata, memReadData,
    input  rdata, ready, err, busy, MemWrite, MemMode, memAddr, memWriteData
  );

  modport slave (
    input  req, we, mode, addr, wdata, memReadData,
    output rdata, ready, err, busy, MemWrite, MemMode, memAddr, memWriteData
  );

endinterface

// File: rtl/mem_access_ctrl_byte_merge.sv
// Replaces one little-endian byte lane of a 32-bit word.
module byte_merge (
  input  logic [31:0] word,
  input  logic [7:0]  byte_val,
  input  logic [1:0]  lane,
  output logic [31:0] merged
);

  // Lane 0 is bits [7:0], lane 3 is bits [31:24].
  always_comb begin
    merged = word;
    case (lane)
      2'd0:    merged = {word[31:8], byte_val};
      2'd1:    merged = {word[31:16], byte_val, word[7:0]};
      2'd2:    merged = {word[31:24], byte_val, word[15:0]};
      2'd3:    merged = {byte_val, word[23:0]};
      default: merged = word;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences CPU load/store requests into exmemory cycles; byte stores to RAM
// go through read-modify-write, stores to ROM are blocked and flagged.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int         WIDTH      = 32,
  parameter int         ADDR_WIDTH = 16,
  parameter logic [3:0] ROM_REGION = REGION_ROM,
  parameter logic [3:0] RAM_REGION = REGION_RAM,
  parameter logic [3:0] IO_REGION  = REGION_IO
) (
  input  logic              clk,
  input  logic              reset,
  mem_access_ctrl_if.slave  bus
);

  state_t                state_r;
  logic                  we_r;
  logic [1:0]            lane_r;
  logic [7:0]            byte_r;
  logic                  err_lat_r;
  logic [WIDTH-1:0]      rdata_r;
  logic                  ready_r;
  logic                  err_r;
  logic                  busy_r;
  logic                  mem_write_r;
  logic [1:0]            mem_mode_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [WIDTH-1:0]      mem_wdata_r;

  logic [3:0]            region_s;
  logic                  byte_store_s;
  logic                  writable_s;
  logic [WIDTH-1:0]      access_wdata_s;
  logic [31:0]           merged_s;

  // Request decode on the live request fields, used only when leaving IDLE.
  always_comb begin
    region_s     = bus.addr[ADDR_WIDTH-1 -: 4];
    byte_store_s = bus.we & is_byte_mode(bus.mode);
    writable_s   = bus.we & ((region_s == RAM_REGION) | (region_s == IO_REGION));
    if (!writable_s) begin
      access_wdata_s = {WIDTH{1'b0}};
    end else if (byte_store_s) begin
      access_wdata_s = {{(WIDTH-8){1'b0}}, bus.wdata[7:0]};
    end else begin
      access_wdata_s = bus.wdata;
    end
  end

  // The read word is merged as it arrives so the write data is registered for RMW_WR.
  byte_merge u_merge (
    .word     (bus.memReadData),
    .byte_val (byte_r),
    .lane     (lane_r),
    .merged   (merged_s)
  );

  // Sequencer state and all registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      we_r        <= 1'b0;
      lane_r      <= 2'd0;
      byte_r      <= 8'd0;
      err_lat_r   <= 1'b0;
      rdata_r     <= {WIDTH{1'b0}};
      ready_r     <= 1'b0;
      err_r       <= 1'b0;
      busy_r      <= 1'b0;
      mem_write_r <= 1'b0;
      mem_mode_r  <= 2'b00;
      mem_addr_r  <= {ADDR_WIDTH{1'b0}};
      mem_wdata_r <= {WIDTH{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          if (bus.req) begin
            we_r      <= bus.we;
            lane_r    <= bus.addr[1:0];
            byte_r    <= bus.wdata[7:0];
            err_lat_r <= bus.we & (region_s == ROM_REGION);
            busy_r    <= 1'b1;
            if (byte_store_s && (region_s == RAM_REGION)) begin
              state_r     <= RMW_RD;
              mem_addr_r  <= {bus.addr[ADDR_WIDTH-1:2], 2'b00};
              mem_mode_r  <= MODE_WORD;
              mem_write_r <= 1'b0;
              mem_wdata_r <= {WIDTH{1'b0}};
            end else begin
              state_r     <= ACCESS;
              mem_addr_r  <= bus.addr;
              mem_mode_r  <= norm_mode(bus.mode);
              mem_write_r <= writable_s;
              mem_wdata_r <= access_wdata_s;
            end
          end else begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        ACCESS: begin
          if (!we_r) begin
            rdata_r <= bus.memReadData;
          end else begin
            rdata_r <= rdata_r;
          end
          state_r     <= DONE;
          ready_r     <= 1'b1;
          err_r       <= err_lat_r;
          mem_write_r <= 1'b0;
          mem_wdata_r <= {WIDTH{1'b0}};
        end
        RMW_RD: begin
          state_r     <= RMW_WR;
          mem_write_r <= 1'b1;
          mem_wdata_r <= merged_s;
        end
        RMW_WR: begin
          state_r     <= DONE;
          ready_r     <= 1'b1;
          err_r       <= err_lat_r;
          mem_write_r <= 1'b0;
          mem_wdata_r <= {WIDTH{1'b0}};
        end
        DONE: begin
          state_r <= IDLE;
          ready_r <= 1'b0;
          err_r   <= 1'b0;
          busy_r  <= 1'b0;
        end
        default: begin
          state_r     <= IDLE;
          ready_r     <= 1'b0;
          err_r       <= 1'b0;
          busy_r      <= 1'b0;
          mem_write_r <= 1'b0;
          mem_wdata_r <= {WIDTH{1'b0}};
        end
      endcase
    end
  end

  // Write strobe is gated so no write reaches memory while reset is asserted.
  assign bus.MemWrite     = mem_write_r & ~reset;
  assign bus.MemMode      = mem_mode_r;
  assign bus.memAddr      = mem_addr_r;
  assign bus.memWriteData = mem_wdata_r;
  assign bus.rdata        = rdata_r;
  assign bus.ready        = ready_r;
  assign bus.err          = err_r;
  assign bus.busy         = busy_r;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed self-checking bench for mem_access_ctrl with a small exmemory model.
module tb_mem_access_ctrl;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  mem_access_ctrl_if #(.WIDTH(32), .ADDR_WIDTH(16)) mif ();

  mem_access_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif.slave)
  );

  logic [31:0] bm_word;
  logic [7:0]  bm_byte;
  logic [1:0]  bm_lane;
  logic [31:0] bm_merged;

  byte_merge u_bm (
    .word     (bm_word),
    .byte_val (bm_byte),
    .lane     (bm_lane),
    .merged   (bm_merged)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exmemory model: RAM at 0x1xxx, LED port at 0xFFFC, ROM returns its address
  logic [31:0] ram [0:1023];
  logic [7:0]  leds;
  logic [31:0] rd_word;
  logic [7:0]  rd_byte;

  always_comb begin
    rd_word = 32'd0;
    case (mif.memAddr[15:12])
      4'h1:    rd_word = ram[mif.memAddr[11:2]];
      4'hf:    rd_word = {24'd0, leds};
      default: rd_word = {16'd0, mif.memAddr};
    endcase
    rd_byte = rd_word[8*mif.memAddr[1:0] +: 8];
    case (mif.MemMode)
      2'b01:   mif.memReadData = {{24{rd_byte[7]}}, rd_byte};
      2'b10:   mif.memReadData = {24'd0, rd_byte};
      default: mif.memReadData = rd_word;
    endcase
  end

  initial leds = 8'd0;

  always @(posedge clk) begin
    if (mif.MemWrite) begin
      if (mif.memAddr[15:12] == 4'h1) ram[mif.memAddr[11:2]] <= mif.memWriteData;
      if (mif.memAddr == 16'hfffc) leds <= mif.memWriteData[7:0];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // results of the last transaction
  int          t_cycles;
  int          t_nwr;
  logic [31:0] t_rdata;
  logic        t_err;
  logic [15:0] t_addr1;
  logic [1:0]  t_mode1;
  logic [15:0] t_wr_addr;
  logic [31:0] t_wr_data;

  task automatic run_req(input logic w, input logic [1:0] m, input logic [15:0] a, input logic [31:0] d);
    logic got;
    @(negedge clk);
    mif.we = w; mif.mode = m; mif.addr = a; mif.wdata = d; mif.req = 1'b1;
    got = 1'b0; t_cycles = 0; t_nwr = 0; t_rdata = 32'd0; t_err = 1'b0;
    t_wr_addr = 16'd0; t_wr_data = 32'd0;
    for (int i = 1; i <= 8 && !got; i++) begin
      @(negedge clk);
      if (i == 1) begin
        t_addr1 = mif.memAddr;
        t_mode1 = mif.MemMode;
      end
      if (mif.MemWrite) begin
        t_nwr++;
        t_wr_addr = mif.memAddr;
        t_wr_data = mif.memWriteData;
      end
      if (mif.ready) begin
        got = 1'b1;
        t_cycles = i;
        t_rdata = mif.rdata;
        t_err = mif.err;
        mif.req = 1'b0;
      end
    end
    if (!got) begin
      chk("ready_timeout", 32'd0, 32'd1);
      mif.req = 1'b0;
    end
  endtask

  initial begin
    total = 0; bad = 0;
    reset = 1'b1;
    mif.req = 1'b0; mif.we = 1'b0; mif.mode = 2'b00; mif.addr = 16'd0; mif.wdata = 32'd0;

    // byte_merge standalone over all lanes
    bm_word = 32'h11223344; bm_byte = 8'hab;
    bm_lane = 2'd0; #1 chk("merge_lane0", bm_merged, 32'h112233ab);
    bm_lane = 2'd1; #1 chk("merge_lane1", bm_merged, 32'h1122ab44);
    bm_lane = 2'd2; #1 chk("merge_lane2", bm_merged, 32'h11ab3344);
    bm_lane = 2'd3; #1 chk("merge_lane3", bm_merged, 32'hab223344);

    // reset state
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, mif.ready}, 32'd0);
    chk("rst_busy", {31'd0, mif.busy}, 32'd0);
    chk("rst_err", {31'd0, mif.err}, 32'd0);
    chk("rst_memwrite", {31'd0, mif.MemWrite}, 32'd0);
    chk("rst_memaddr", {16'd0, mif.memAddr}, 32'd0);
    chk("rst_memmode", {30'd0, mif.MemMode}, 32'd0);
    chk("rst_wdata", mif.memWriteData, 32'd0);
    chk("rst_rdata", mif.rdata, 32'd0);
    reset = 1'b0;

    // word stores preload RAM
    run_req(1'b1, 2'b00, 16'h1004, 32'hdeadbeef);
    chk("wst_cycles", t_cycles, 32'd2);
    chk("wst_nwr", t_nwr, 32'd1);
    chk("wst_addr", {16'd0, t_wr_addr}, 32'h1004);
    chk("wst_data", t_wr_data, 32'hdeadbeef);
    chk("wst_err", {31'd0, t_err}, 32'd0);
    run_req(1'b1, 2'b00, 16'h1008, 32'h11223344);
    chk("wst2_nwr", t_nwr, 32'd1);

    // word load
    run_req(1'b0, 2'b00, 16'h1004, 32'd0);
    chk("wld_cycles", t_cycles, 32'd2);
    chk("wld_rdata", t_rdata, 32'hdeadbeef);
    chk("wld_nwr", t_nwr, 32'd0);

    // RAM byte store via read-modify-write
    run_req(1'b1, 2'b01, 16'h1006, 32'h00000055);
    chk("rmw_cycles", t_cycles, 32'd3);
    chk("rmw_rd_addr", {16'd0, t_addr1}, 32'h1004);
    chk("rmw_nwr", t_nwr, 32'd1);
    chk("rmw_wr_addr", {16'd0, t_wr_addr}, 32'h1004);
    chk("rmw_wr_data", t_wr_data, 32'hde55beef);
    run_req(1'b0, 2'b00, 16'h1004, 32'd0);
    chk("rmw_reload", t_rdata, 32'hde55beef);

    // mode 11 behaves as word; signed byte load passes mode through
    run_req(1'b0, 2'b11, 16'h1004, 32'd0);
    chk("m11_memmode", {30'd0, t_mode1}, 32'd0);
    chk("m11_rdata", t_rdata, 32'hde55beef);
    run_req(1'b0, 2'b01, 16'h1007, 32'd0);
    chk("bld_memmode", {30'd0, t_mode1}, 32'd1);
    chk("bld_rdata", t_rdata, 32'hffffffde);

    // I/O byte store is a single write cycle
    run_req(1'b1, 2'b10, 16'hfffc, 32'h123456a5);
    chk("io_cycles", t_cycles, 32'd2);
    chk("io_nwr", t_nwr, 32'd1);
    chk("io_addr", {16'd0, t_wr_addr}, 32'hfffc);
    chk("io_data", t_wr_data, 32'h000000a5);
    chk("io_leds", {24'd0, leds}, 32'h000000a5);

    // ROM store blocked and flagged
    run_req(1'b1, 2'b00, 16'h0010, 32'hcafef00d);
    chk("rom_cycles", t_cycles, 32'd2);
    chk("rom_nwr", t_nwr, 32'd0);
    chk("rom_err", {31'd0, t_err}, 32'd1);

    // back-to-back with req held through ready
    @(negedge clk);
    mif.we = 1'b0; mif.mode = 2'b00; mif.addr = 16'h1008; mif.req = 1'b1;
    @(negedge clk);
    chk("b2b_busy1", {31'd0, mif.busy}, 32'd1);
    @(negedge clk);
    chk("b2b_ready1", {31'd0, mif.ready}, 32'd1);
    chk("b2b_rdata1", mif.rdata, 32'h11223344);
    mif.addr = 16'h1004;
    @(negedge clk);
    chk("b2b_gap_busy", {31'd0, mif.busy}, 32'd0);
    chk("b2b_gap_ready", {31'd0, mif.ready}, 32'd0);
    @(negedge clk);
    chk("b2b_busy2", {31'd0, mif.busy}, 32'd1);
    chk("b2b_addr2", {16'd0, mif.memAddr}, 32'h1004);
    @(negedge clk);
    chk("b2b_ready2", {31'd0, mif.ready}, 32'd1);
    chk("b2b_rdata2", mif.rdata, 32'hde55beef);
    mif.req = 1'b0;
    @(negedge clk);
    chk("b2b_idle_busy", {31'd0, mif.busy}, 32'd0);

    // reset during RMW_WR of a byte store to 0x1008
    mif.we = 1'b1; mif.mode = 2'b10; mif.addr = 16'h1008; mif.wdata = 32'h00000077; mif.req = 1'b1;
    @(negedge clk);
    chk("rst_rmw_rd_addr", {16'd0, mif.memAddr}, 32'h1008);
    @(negedge clk);
    reset = 1'b1;
    mif.req = 1'b0;
    #1 chk("rst_rmw_memwrite", {31'd0, mif.MemWrite}, 32'd0);
    @(negedge clk);
    chk("rst_rmw_ready", {31'd0, mif.ready}, 32'd0);
    chk("rst_rmw_busy", {31'd0, mif.busy}, 32'd0);
    reset = 1'b0;
    run_req(1'b0, 2'b00, 16'h1008, 32'd0);
    chk("rst_rmw_word", t_rdata, 32'h11223344);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
